// File: rtl/axi_log_pkg.sv
// Shared constants, state encoding and address helper for the log drain
// controller and the logger it empties.
package axi_log_pkg;

  localparam int EXT_DATA_BITW   = 32;
  localparam int WORDS_PER_ENTRY = 3;
  localparam int LOG_ENTRIES     = 1024 * 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    CLEAR,
    HOLD
  } drain_state_e;

  // Byte address of word w of entry e; entries are NPB words wide.
  function automatic logic [EXT_DATA_BITW-1:0] word_addr(
    input logic [EXT_DATA_BITW-1:0] e,
    input logic [EXT_DATA_BITW-1:0] w,
    input int                       npb
  );
    return ((e * EXT_DATA_BITW'(npb)) + w) << 2;
  endfunction

endpackage

// File: rtl/axi_log_drain_ctrl.sv
// Drains the logger BRAMs entry by entry onto a valid/ready word stream,
// then pulses a clear to the logger and waits out its clear sweep.
module axi_log_drain_ctrl
  import axi_log_pkg::*;
#(
  parameter int NUM_PAR_BRAMS = WORDS_PER_ENTRY,
  parameter int NUM_SER_BRAMS = 12,
  parameter int CNT_BITW      = $clog2(1024 * NUM_SER_BRAMS) + 1
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic                     Start_SI,
  input  logic                     Abort_SI,
  input  logic                     AutoDrain_SI,
  input  logic                     LogFull_SI,
  input  logic [CNT_BITW-1:0]      NumEntries_DI,
  output logic                     BramEn_SO,
  output logic [EXT_DATA_BITW-1:0] BramAddr_DO,
  output logic [3:0]               BramWrEn_SO,
  input  logic [EXT_DATA_BITW-1:0] BramRd_DI,
  output logic [EXT_DATA_BITW-1:0] Out_DO,
  output logic                     OutValid_SO,
  input  logic                     OutReady_SI,
  output logic                     OutLast_SO,
  output logic                     LogClear_SO,
  output logic                     Busy_SO
);

  localparam int LogEntries = 1024 * NUM_SER_BRAMS;
  localparam int WordBitw   = (NUM_PAR_BRAMS > 1) ? $clog2(NUM_PAR_BRAMS) : 1;
  localparam int HoldBitw   = $clog2(LogEntries + 1) + 1;
  localparam logic [WordBitw-1:0] LastWord = WordBitw'(NUM_PAR_BRAMS - 1);

  drain_state_e               state_q, state_d;
  logic [CNT_BITW-1:0]        entries_q, entries_d;
  logic [CNT_BITW-1:0]        entry_q, entry_d;
  logic [WordBitw-1:0]        word_q, word_d;
  logic                       abort_q, abort_d;
  logic [EXT_DATA_BITW-1:0]   out_q, out_d;
  logic [HoldBitw-1:0]        hold_q, hold_d;

  logic                       bramEn, outValid, outLast, logClear;
  logic                       lastWord;
  logic [CNT_BITW-1:0]        clampedCnt;
  logic [EXT_DATA_BITW-1:0]   bramAddr;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      entries_q <= '0;
      entry_q   <= '0;
      word_q    <= '0;
      abort_q   <= 1'b0;
      out_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      entries_q <= entries_d;
      entry_q   <= entry_d;
      word_q    <= word_d;
      abort_q   <= abort_d;
      out_q     <= out_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    entries_d  = entries_q;
    entry_d    = entry_q;
    word_d     = word_q;
    abort_d    = abort_q;
    out_d      = out_q;
    hold_d     = hold_q;
    bramEn     = 1'b0;
    outValid   = 1'b0;
    outLast    = 1'b0;
    logClear   = 1'b0;
    bramAddr   = '0;
    lastWord   = (word_q == LastWord) && (entry_q == entries_q - CNT_BITW'(1));
    clampedCnt = (32'(NumEntries_DI) > 32'(LogEntries)) ? CNT_BITW'(LogEntries)
                                                        : NumEntries_DI;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (Start_SI || (AutoDrain_SI && LogFull_SI)) begin
          entries_d = clampedCnt;
          entry_d   = '0;
          word_d    = '0;
          state_d   = (clampedCnt == '0) ? CLEAR : FETCH;
        end
      end
      FETCH: begin
        if (abort_q || Abort_SI) begin
          state_d = IDLE;
        end else begin
          bramEn  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_d   = BramRd_DI;
        abort_d = abort_q || Abort_SI;
        state_d = SEND;
      end
      SEND: begin
        // An abort that is already pending suppresses OutLast so the consumer
        // never sees a "last" marker on a truncated drain.
        outValid = 1'b1;
        outLast  = lastWord && !abort_q;
        abort_d  = abort_q || Abort_SI;
        if (OutReady_SI) begin
          if (lastWord && !abort_q) begin
            state_d = CLEAR;
          end else if (abort_q || Abort_SI) begin
            state_d = IDLE;
          end else begin
            bramEn  = 1'b1;
            state_d = CAPTURE;
            if (word_q == LastWord) begin
              word_d  = '0;
              entry_d = entry_q + CNT_BITW'(1);
            end else begin
              word_d = word_q + WordBitw'(1);
            end
          end
        end
      end
      CLEAR: begin
        logClear = 1'b1;
        hold_d   = '0;
        state_d  = HOLD;
      end
      HOLD: begin
        if (hold_q == HoldBitw'(LogEntries)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HoldBitw'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The read address always follows the counters as they will be after
    // this cycle, so a handshake fetches the next word without a bubble.
    if (bramEn) begin
      bramAddr = word_addr(EXT_DATA_BITW'(entry_d), EXT_DATA_BITW'(word_d), NUM_PAR_BRAMS);
    end
  end

  assign BramEn_SO   = bramEn;
  assign BramAddr_DO = bramAddr;
  assign BramWrEn_SO = 4'b0000;
  assign Out_DO      = out_q;
  assign OutValid_SO = outValid;
  assign OutLast_SO  = outLast;
  assign LogClear_SO = logClear;
  assign Busy_SO     = (state_q != IDLE);

endmodule

// File: tb/tb_axi_log_drain_ctrl.sv
// Self-checking bench for axi_log_drain_ctrl: a BRAM model, a stream/read
// monitor and a queue-based reference of the expected drain.
module tb_axi_log_drain_ctrl;
  import axi_log_pkg::*;

  // Two serial BRAMs keep the full-log clamp drain short enough to simulate.
  localparam int NPB = 3;
  localparam int NSB = 2;
  localparam int CBW = 16;
  localparam int LE  = 1024 * NSB;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, abort, autoDrain, logFull, outReady;
  logic [CBW-1:0]  numEntries;
  logic            bramEn, outValid, outLast, logClear, busy;
  logic [31:0]     bramAddr, bramRd, outData;
  logic [3:0]      bramWrEn;

  int checks = 0;
  int errors = 0;

  logic [31:0] salt;
  int          readyMode;
  int          stallCnt;

  logic [31:0] rdAddrQ[$];
  logic [31:0] outDataQ[$];
  logic        outLastQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  int          clearCnt, holdLen, stallViol, wrEnViol;
  bit          inHold, prevStall;
  logic [31:0] prevData;
  logic        prevLast;

  axi_log_drain_ctrl #(
    .NUM_PAR_BRAMS(NPB),
    .NUM_SER_BRAMS(NSB),
    .CNT_BITW     (CBW)
  ) dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .Start_SI     (start),
    .Abort_SI     (abort),
    .AutoDrain_SI (autoDrain),
    .LogFull_SI   (logFull),
    .NumEntries_DI(numEntries),
    .BramEn_SO    (bramEn),
    .BramAddr_DO  (bramAddr),
    .BramWrEn_SO  (bramWrEn),
    .BramRd_DI    (bramRd),
    .Out_DO       (outData),
    .OutValid_SO  (outValid),
    .OutReady_SI  (outReady),
    .OutLast_SO   (outLast),
    .LogClear_SO  (logClear),
    .Busy_SO      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bramWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bramEn) bramRd <= bramWord(bramAddr);
  end

  // Ready generator: 0 always ready, 1 random, 2 five stall cycles per word, else never.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: outReady = 1'b1;
      1: outReady = 1'($urandom_range(0, 1));
      2: begin
        if (outValid) begin
          outReady = (stallCnt == 5);
          stallCnt = (stallCnt == 5) ? 0 : stallCnt + 1;
        end else begin
          outReady = 1'b0;
        end
      end
      default: outReady = 1'b0;
    endcase
  end

  // Monitor: records reads, handshakes, clear pulses, hold length and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
      inHold    = 1'b0;
    end else begin
      if (bramEn) rdAddrQ.push_back(bramAddr);
      if (bramWrEn !== 4'b0000) wrEnViol++;
      if (prevStall && (outValid !== 1'b1 || outData !== prevData || outLast !== prevLast))
        stallViol++;
      prevStall = outValid && !outReady;
      prevData  = outData;
      prevLast  = outLast;
      if (outValid && outReady) begin
        outDataQ.push_back(outData);
        outLastQ.push_back(outLast);
      end
      if (logClear) begin
        clearCnt++;
        inHold  = 1'b1;
        holdLen = 0;
      end else if (inHold) begin
        if (busy) holdLen++;
        else inHold = 1'b0;
      end
    end
  end

  task automatic clearLog();
    rdAddrQ   = {};
    outDataQ  = {};
    outLastQ  = {};
    clearCnt  = 0;
    holdLen   = 0;
    stallViol = 0;
    inHold    = 1'b0;
    stallCnt  = 0;
  endtask

  // Reference drain: words in entry-major order, truncated to maxWords.
  task automatic modelDrain(input int n, input int maxWords);
    logic [31:0] a;
    expAddrQ = {};
    expDataQ = {};
    for (int e = 0; e < n; e++) begin
      for (int w = 0; w < NPB; w++) begin
        if (expAddrQ.size() < maxWords) begin
          a = 32'((e * NPB + w) * 4);
          expAddrQ.push_back(a);
          expDataQ.push_back(bramWord(a));
        end
      end
    end
  endtask

  task automatic startDrain(input int n);
    @(posedge clk); #1;
    numEntries = CBW'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #17;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", outValid); end
    checks++; if (outLast !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %b want 0", outLast); end
    checks++; if (bramEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_bramen got %b want 0", bramEn); end
    checks++; if (logClear !== 1'b0) begin errors++; $display("[TB] FAIL reset_clear got %b want 0", logClear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (bramAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", bramAddr); end
    checks++; if (outData !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", outData); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_drain();
    bit to;
    clearLog();
    salt      = $urandom;
    readyMode = 0;
    startDrain(2);
    for (int i = 0; i < 100 && clearCnt == 0; i++) begin
      @(posedge clk); #1;
    end
    startDrain(1);
    waitIdle(3000, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout busy=%b want 0", busy); end
    modelDrain(2, 1 << 30);
    checks++; if (rdAddrQ.size() != 6) begin errors++; $display("[TB] FAIL basic_reads got %0d want 6", rdAddrQ.size()); end
    checks++; if (outDataQ.size() != 6) begin errors++; $display("[TB] FAIL basic_words got %0d want 6", outDataQ.size()); end
    for (int i = 0; i < 6 && i < rdAddrQ.size(); i++) begin
      checks++; if (rdAddrQ[i] !== expAddrQ[i]) begin errors++; $display("[TB] FAIL basic_addr[%0d] got %h want %h", i, rdAddrQ[i], expAddrQ[i]); end
    end
    for (int i = 0; i < 6 && i < outDataQ.size(); i++) begin
      checks++; if (outDataQ[i] !== expDataQ[i]) begin errors++; $display("[TB] FAIL basic_data[%0d] got %h want %h", i, outDataQ[i], expDataQ[i]); end
      checks++; if (outLastQ[i] !== (i == 5)) begin errors++; $display("[TB] FAIL basic_last[%0d] got %b want %b", i, outLastQ[i], i == 5); end
    end
    checks++; if (clearCnt != 1) begin errors++; $display("[TB] FAIL basic_clears got %0d want 1", clearCnt); end
    checks++; if (holdLen != LE + 1) begin errors++; $display("[TB] FAIL basic_hold got %0d want %0d", holdLen, LE + 1); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_start_ignored busy=%b want 0", busy); end
  endtask

  task automatic test_stall();
    bit to;
    clearLog();
    salt      = $urandom;
    readyMode = 2;
    startDrain(1);
    repeat (3) @(posedge clk);
    startDrain(5);
    waitIdle(3000, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout busy=%b want 0", busy); end
    modelDrain(1, 1 << 30);
    checks++; if (outDataQ.size() != 3) begin errors++; $display("[TB] FAIL stall_handshakes got %0d want 3", outDataQ.size()); end
    for (int i = 0; i < 3 && i < outDataQ.size(); i++) begin
      checks++; if (outDataQ[i] !== expDataQ[i]) begin errors++; $display("[TB] FAIL stall_data[%0d] got %h want %h", i, outDataQ[i], expDataQ[i]); end
      checks++; if (outLastQ[i] !== (i == 2)) begin errors++; $display("[TB] FAIL stall_last[%0d] got %b want %b", i, outLastQ[i], i == 2); end
    end
    checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL stall_stability got %0d changes want 0", stallViol); end
    checks++; if (clearCnt != 1) begin errors++; $display("[TB] FAIL stall_clears got %0d want 1", clearCnt); end
  endtask

  task automatic test_zero_entries();
    bit to;
    bit seen;
    clearLog();
    readyMode = 0;
    startDrain(0);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (clearCnt > 0) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL zero_clear_latency clears=%0d want 1 within 2 cycles", clearCnt); end
    waitIdle(3000, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL zero_timeout busy=%b want 0", busy); end
    checks++; if (rdAddrQ.size() != 0) begin errors++; $display("[TB] FAIL zero_reads got %0d want 0", rdAddrQ.size()); end
    checks++; if (clearCnt != 1) begin errors++; $display("[TB] FAIL zero_clears got %0d want 1", clearCnt); end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int it = 0; it < 4; it++) begin
      clearLog();
      salt      = $urandom;
      n         = int'($urandom_range(1, 5));
      readyMode = int'($urandom_range(0, 1));
      startDrain(n);
      waitIdle(3000, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL rand%0d_timeout busy=%b want 0", it, busy); end
      modelDrain(n, 1 << 30);
      checks++; if (outDataQ.size() != expDataQ.size()) begin errors++; $display("[TB] FAIL rand%0d_words got %0d want %0d", it, outDataQ.size(), expDataQ.size()); end
      checks++; if (rdAddrQ.size() != expAddrQ.size()) begin errors++; $display("[TB] FAIL rand%0d_reads got %0d want %0d", it, rdAddrQ.size(), expAddrQ.size()); end
      for (int i = 0; i < outDataQ.size() && i < expDataQ.size(); i++) begin
        checks++; if (outDataQ[i] !== expDataQ[i]) begin errors++; $display("[TB] FAIL rand%0d_data[%0d] got %h want %h", it, i, outDataQ[i], expDataQ[i]); end
        checks++; if (outLastQ[i] !== (i == expDataQ.size() - 1)) begin errors++; $display("[TB] FAIL rand%0d_last[%0d] got %b", it, i, outLastQ[i]); end
      end
      for (int i = 0; i < rdAddrQ.size() && i < expAddrQ.size(); i++) begin
        checks++; if (rdAddrQ[i] !== expAddrQ[i]) begin errors++; $display("[TB] FAIL rand%0d_addr[%0d] got %h want %h", it, i, rdAddrQ[i], expAddrQ[i]); end
      end
      checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL rand%0d_stability got %0d want 0", it, stallViol); end
      checks++; if (clearCnt != 1) begin errors++; $display("[TB] FAIL rand%0d_clears got %0d want 1", it, clearCnt); end
    end
  endtask

  task automatic test_autodrain_clamp();
    bit to;
    int n;
    int lastCnt;
    clearLog();
    salt      = $urandom;
    readyMode = 0;
    @(posedge clk); #1;
    numEntries = CBW'(50000);
    autoDrain  = 1'b1;
    @(posedge clk); #1;
    logFull    = 1'b1;
    @(posedge clk); #1;
    logFull    = 1'b0;
    waitIdle(20000, to);
    autoDrain  = 1'b0;
    checks++; if (to) begin errors++; $display("[TB] FAIL clamp_timeout busy=%b want 0", busy); end
    n = (50000 > LE) ? LE : 50000;
    modelDrain(n, 1 << 30);
    checks++; if (outDataQ.size() != n * NPB) begin errors++; $display("[TB] FAIL clamp_words got %0d want %0d", outDataQ.size(), n * NPB); end
    checks++; if (rdAddrQ.size() == 0 || rdAddrQ[rdAddrQ.size() - 1] !== 32'h5FFC) begin errors++; $display("[TB] FAIL clamp_last_addr reads=%0d want last 5ffc", rdAddrQ.size()); end
    for (int i = 0; i < rdAddrQ.size() && i < expAddrQ.size(); i++) begin
      checks++; if (rdAddrQ[i] !== expAddrQ[i]) begin errors++; $display("[TB] FAIL clamp_addr[%0d] got %h want %h", i, rdAddrQ[i], expAddrQ[i]); end
    end
    lastCnt = 0;
    for (int i = 0; i < outDataQ.size() && i < expDataQ.size(); i++) begin
      checks++; if (outDataQ[i] !== expDataQ[i]) begin errors++; $display("[TB] FAIL clamp_data[%0d] got %h want %h", i, outDataQ[i], expDataQ[i]); end
      if (outLastQ[i]) lastCnt++;
    end
    checks++; if (lastCnt != 1 || outLastQ.size() == 0 || outLastQ[outLastQ.size() - 1] !== 1'b1) begin errors++; $display("[TB] FAIL clamp_last_flags got %0d want 1 on final word", lastCnt); end
    checks++; if (clearCnt != 1) begin errors++; $display("[TB] FAIL clamp_clears got %0d want 1", clearCnt); end
  endtask

  task automatic test_abort();
    bit to;
    clearLog();
    salt      = $urandom;
    readyMode = 0;
    startDrain(4);
    for (int i = 0; i < 20 && outDataQ.size() < 1; i++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    waitIdle(50, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL abort_timeout busy=%b want 0", busy); end
    modelDrain(4, 2);
    checks++; if (outDataQ.size() != 2) begin errors++; $display("[TB] FAIL abort_words got %0d want 2", outDataQ.size()); end
    for (int i = 0; i < 2 && i < outDataQ.size(); i++) begin
      checks++; if (outDataQ[i] !== expDataQ[i]) begin errors++; $display("[TB] FAIL abort_data[%0d] got %h want %h", i, outDataQ[i], expDataQ[i]); end
      checks++; if (outLastQ[i] !== 1'b0) begin errors++; $display("[TB] FAIL abort_last[%0d] got %b want 0", i, outLastQ[i]); end
    end
    checks++; if (rdAddrQ.size() != 2) begin errors++; $display("[TB] FAIL abort_reads got %0d want 2", rdAddrQ.size()); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (clearCnt != 0) begin errors++; $display("[TB] FAIL abort_clears got %0d want 0", clearCnt); end

    // Abort while the first read is still pending: nothing may be fetched.
    clearLog();
    @(posedge clk); #1;
    numEntries = CBW'(3);
    start      = 1'b1;
    abort      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    @(posedge clk); #1;
    abort      = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rdAddrQ.size() != 0) begin errors++; $display("[TB] FAIL abort_fetch_reads got %0d want 0", rdAddrQ.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_fetch_busy got %b want 0", busy); end
    checks++; if (clearCnt != 0) begin errors++; $display("[TB] FAIL abort_fetch_clears got %0d want 0", clearCnt); end
  endtask

  task automatic test_reset_mid_send();
    bit to;
    clearLog();
    salt      = $urandom;
    readyMode = 3;
    startDrain(3);
    for (int i = 0; i < 10 && !outValid; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL rst_send_reached valid=%b want 1", outValid); end
    rst = 1'b1;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b want 0", outValid); end
    checks++; if (outData !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_data got %h want 0", outData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (bramEn !== 1'b0 || bramAddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_bram en=%b addr=%h want 0", bramEn, bramAddr); end
    checks++; if (outLast !== 1'b0 || logClear !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_last_clear last=%b clear=%b want 0", outLast, logClear); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (clearCnt != 0) begin errors++; $display("[TB] FAIL rst_mid_clears got %0d want 0", clearCnt); end
    clearLog();
    readyMode = 0;
    startDrain(1);
    waitIdle(3000, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL rst_restart_timeout busy=%b want 0", busy); end
    modelDrain(1, 1 << 30);
    checks++; if (rdAddrQ.size() == 0 || rdAddrQ[0] !== 32'h0) begin errors++; $display("[TB] FAIL rst_restart_addr reads=%0d want first 0", rdAddrQ.size()); end
    checks++; if (outDataQ.size() != 3) begin errors++; $display("[TB] FAIL rst_restart_words got %0d want 3", outDataQ.size()); end
    for (int i = 0; i < 3 && i < outDataQ.size(); i++) begin
      checks++; if (outDataQ[i] !== expDataQ[i]) begin errors++; $display("[TB] FAIL rst_restart_data[%0d] got %h want %h", i, outDataQ[i], expDataQ[i]); end
    end
  endtask

  initial begin
    start      = 1'b0;
    abort      = 1'b0;
    autoDrain  = 1'b0;
    logFull    = 1'b0;
    outReady   = 1'b0;
    numEntries = '0;
    salt       = 32'h0;
    readyMode  = 0;
    wrEnViol   = 0;
    clearLog();

    test_reset();
    test_basic_drain();
    test_stall();
    test_zero_entries();
    test_random();
    test_autodrain_clamp();
    test_abort();
    test_reset_mid_send();

    checks++; if (wrEnViol != 0) begin errors++; $display("[TB] FAIL bram_wren got %0d nonzero cycles want 0", wrEnViol); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
